// File: rtl/axi4_mem_port_arbiter_if.sv
// axi4_mem_port_arbiter_if: request/beat/memory bundle between the burst engines, the arbiter and axi4_memory.
//   wr_*  write engine: req/len in, gnt/beat_ready/done out, beat valid/addr/data in
//   rd_*  read engine: req/len in, gnt/beat_ready out, beat valid/addr in, data/data_valid/done out
//   mem_* memory port: en/we/addr/wdata out of the arbiter, rdata back one cycle after a read
//   slave modport is the arbiter side, master modport the engine/memory side.
interface axi4_mem_port_arbiter_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 1024
);
    localparam int AW = $clog2(MEMORY_DEPTH);
    logic                  wr_req, wr_gnt, wr_beat_valid, wr_beat_ready, wr_done;
    logic [7:0]            wr_len, rd_len;
    logic [AW-1:0]         wr_addr, rd_addr, mem_addr;
    logic [DATA_WIDTH-1:0] wr_data, rd_data, mem_wdata, mem_rdata;
    logic                  rd_req, rd_gnt, rd_beat_valid, rd_beat_ready, rd_data_valid, rd_done;
    logic                  mem_en, mem_we;
    modport slave (
        input  wr_req, wr_len, wr_beat_valid, wr_addr, wr_data,
        input  rd_req, rd_len, rd_beat_valid, rd_addr, mem_rdata,
        output wr_gnt, wr_beat_ready, wr_done,
        output rd_gnt, rd_beat_ready, rd_data, rd_data_valid, rd_done,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output wr_req, wr_len, wr_beat_valid, wr_addr, wr_data,
        output rd_req, rd_len, rd_beat_valid, rd_addr, mem_rdata,
        input  wr_gnt, wr_beat_ready, wr_done,
        input  rd_gnt, rd_beat_ready, rd_data, rd_data_valid, rd_done,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/axi4_mem_port_arbiter.sv
// axi4_mem_port_arbiter: shares single-port axi4_memory between write and read burst engines, one burst per grant.
//   ACLK/ARESET  clock, asynchronous active-high reset
//   bus          axi4_mem_port_arbiter_if.slave: engine requests/beats, read data return, memory port
//   AXI4_ARB_FIXED_PRIO_EN defined: write always wins a tie; otherwise round-robin between bursts.
module axi4_mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    axi4_mem_port_arbiter_if.slave   bus
);
    localparam int AW = $clog2(MEMORY_DEPTH);
    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, RD_DRAIN} state_t;
    state_t        state, state_nxt;
    logic [7:0]    beat_cnt;
    logic [AW-1:0] addr_nxt;
    logic          wr_acc, rd_acc, last_beat, wr_win;
    logic          rd_v1, rd_v2, rd_l1, rd_l2;

    assign bus.wr_gnt        = state == WR_BURST;
    assign bus.rd_gnt        = state == RD_BURST || state == RD_DRAIN;
    assign bus.wr_beat_ready = state == WR_BURST;
    assign bus.rd_beat_ready = state == RD_BURST;
    assign wr_acc    = state == WR_BURST && bus.wr_beat_valid;
    assign rd_acc    = state == RD_BURST && bus.rd_beat_valid;
    assign last_beat = beat_cnt == 8'd0;
    // Read data is valid two cycles after accept: one for the registered
    // memory request, one for the memory's read latency.
    assign bus.rd_data_valid = rd_v2;
    assign bus.rd_done       = rd_l2;
    assign bus.rd_data       = rd_v2 ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
    assign addr_nxt = wr_acc ? bus.wr_addr : rd_acc ? bus.rd_addr : bus.mem_addr;

`ifdef AXI4_ARB_FIXED_PRIO_EN
    assign wr_win = bus.wr_req;
`else
    logic last_wr;
    // Reset as if read owned last, so write wins the first tie.
    always_ff @(posedge ACLK or posedge ARESET)
        if (ARESET)
            last_wr <= 1'b0;
        else if (wr_acc && last_beat)
            last_wr <= 1'b1;
        else if (state == RD_DRAIN && rd_l2)
            last_wr <= 1'b0;
    assign wr_win = bus.wr_req && (!bus.rd_req || !last_wr);
`endif

    always_ff @(posedge ACLK or posedge ARESET)
        if (ARESET)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = wr_win ? WR_BURST : bus.rd_req ? RD_BURST : IDLE;
            WR_BURST: state_nxt = wr_acc && last_beat ? IDLE : WR_BURST;
            RD_BURST: state_nxt = rd_acc && last_beat ? RD_DRAIN : RD_BURST;
            RD_DRAIN: state_nxt = rd_l2 ? IDLE : RD_DRAIN;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET)
        if (ARESET) begin
            beat_cnt      <= 8'd0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.wr_done   <= 1'b0;
            rd_v1         <= 1'b0;
            rd_v2         <= 1'b0;
            rd_l1         <= 1'b0;
            rd_l2         <= 1'b0;
        end else begin
            beat_cnt      <= state == IDLE ? (wr_win ? bus.wr_len : bus.rd_req ? bus.rd_len : beat_cnt)
                                           : (wr_acc || rd_acc) ? beat_cnt - 8'd1 : beat_cnt;
            bus.mem_en    <= wr_acc || rd_acc;
            bus.mem_we    <= wr_acc;
            bus.mem_addr  <= addr_nxt;
            bus.mem_wdata <= wr_acc ? bus.wr_data : bus.mem_wdata;
            bus.wr_done   <= wr_acc && last_beat;
            rd_v1         <= rd_acc;
            rd_v2         <= rd_v1;
            rd_l1         <= rd_acc && last_beat;
            rd_l2         <= rd_l1;
        end
endmodule

// File: tb/tb_axi4_mem_port_arbiter.sv
// tb_axi4_mem_port_arbiter: directed bench for axi4_mem_port_arbiter with a behavioural single-port memory.
module tb_axi4_mem_port_arbiter;
    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] mem [1024];
    logic [1:0] alt_exp [12];

    axi4_mem_port_arbiter_if #(.DATA_WIDTH(32), .MEMORY_DEPTH(1024)) bus ();
    axi4_mem_port_arbiter #(.DATA_WIDTH(32), .MEMORY_DEPTH(1024)) dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bus));

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK)
        if (bus.mem_en) begin
            if (bus.mem_we)
                mem[bus.mem_addr] <= bus.mem_wdata;
            else
                bus.mem_rdata <= mem[bus.mem_addr];
        end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
`ifdef AXI4_ARB_FIXED_PRIO_EN
        alt_exp = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
`else
        alt_exp = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
`endif
        bus.wr_req = 0; bus.wr_len = 0; bus.wr_beat_valid = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.rd_req = 0; bus.rd_len = 0; bus.rd_beat_valid = 0; bus.rd_addr = 0; bus.mem_rdata = 0;
        tick(); tick();
        check("rst_wr_gnt", 32'(bus.wr_gnt), 0);
        check("rst_rd_gnt", 32'(bus.rd_gnt), 0);
        check("rst_mem_en", 32'(bus.mem_en), 0);
        check("rst_rd_valid", 32'(bus.rd_data_valid), 0);
        check("rst_ready", 32'({bus.wr_beat_ready, bus.rd_beat_ready}), 0);
        ARESET = 0;
        tick();
        check("idle_no_req", 32'(bus.wr_gnt | bus.rd_gnt), 0);

        // write burst of 4 beats
        bus.wr_req = 1; bus.wr_len = 3;
        tick();
        check("wr_gnt", 32'(bus.wr_gnt), 1);
        check("wr_ready", 32'(bus.wr_beat_ready), 1);
        bus.wr_req = 0;
        for (int i = 0; i < 4; i++) begin
            bus.wr_beat_valid = 1; bus.wr_addr = 10'(10 + i); bus.wr_data = 32'hA0 + 32'(i);
            tick();
            check("wr_mem_en_we", 32'({bus.mem_en, bus.mem_we}), 3);
            check("wr_mem_addr", 32'(bus.mem_addr), 32'(10 + i));
            check("wr_mem_wdata", bus.mem_wdata, 32'hA0 + 32'(i));
            check("wr_done", 32'(bus.wr_done), 32'(i == 3));
            check("wr_gnt_hold", 32'(bus.wr_gnt), 32'(i != 3));
        end
        bus.wr_beat_valid = 0;
        tick();
        check("wr_after_mem_en", 32'(bus.mem_en), 0);

        // read burst of 2 beats
        bus.rd_req = 1; bus.rd_len = 1;
        tick();
        check("rd_gnt", 32'(bus.rd_gnt), 1);
        check("rd_ready", 32'(bus.rd_beat_ready), 1);
        bus.rd_req = 0; bus.rd_beat_valid = 1; bus.rd_addr = 10;
        tick();
        check("rd0_mem", 32'({bus.mem_en, bus.mem_we}), 2);
        check("rd0_addr", 32'(bus.mem_addr), 10);
        check("rd0_valid_early", 32'(bus.rd_data_valid), 0);
        bus.rd_addr = 11;
        tick();
        check("rd1_addr", 32'(bus.mem_addr), 11);
        check("rd_drain_ready", 32'(bus.rd_beat_ready), 0);
        check("rd0_valid", 32'(bus.rd_data_valid), 1);
        check("rd0_data", bus.rd_data, 32'hA0);
        check("rd0_done", 32'(bus.rd_done), 0);
        bus.rd_beat_valid = 0;
        tick();
        check("rd1_valid", 32'(bus.rd_data_valid), 1);
        check("rd1_data", bus.rd_data, 32'hA1);
        check("rd1_done", 32'(bus.rd_done), 1);
        check("rd_drain_gnt", 32'(bus.rd_gnt), 1);
        check("rd_drain_mem_en", 32'(bus.mem_en), 0);
        tick();
        check("rd_gnt_drop", 32'(bus.rd_gnt), 0);
        check("rd_valid_drop", 32'(bus.rd_data_valid), 0);

        // both requesting, single-beat bursts
        bus.wr_req = 1; bus.rd_req = 1; bus.wr_len = 0; bus.rd_len = 0;
        bus.wr_beat_valid = 1; bus.rd_beat_valid = 1;
        bus.wr_addr = 20; bus.wr_data = 32'hBEEF; bus.rd_addr = 20;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("alt_owner", 32'({bus.rd_gnt, bus.wr_gnt}), 32'(alt_exp[i]));
        end
        bus.wr_req = 0; bus.rd_req = 0; bus.wr_beat_valid = 0; bus.rd_beat_valid = 0;
        tick();
        check("alt_idle", 32'({bus.rd_gnt, bus.wr_gnt}), 0);

        // read request held off by a write burst
        bus.wr_req = 1; bus.wr_len = 1; bus.wr_addr = 30; bus.wr_data = 32'hC0;
        bus.rd_len = 0; bus.rd_addr = 10;
        tick();
        check("blk_wr_gnt", 32'(bus.wr_gnt), 1);
        bus.rd_req = 1; bus.rd_beat_valid = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("blk_rd_gnt", 32'(bus.rd_gnt), 0);
            check("blk_rd_ready", 32'(bus.rd_beat_ready), 0);
        end
        bus.wr_req = 0; bus.wr_beat_valid = 1;
        tick();
        check("blk_wr_done0", 32'(bus.wr_done), 0);
        tick();
        check("blk_wr_done1", 32'(bus.wr_done), 1);
        check("blk_gap", 32'({bus.rd_gnt, bus.wr_gnt}), 0);
        bus.wr_beat_valid = 0;
        tick();
        check("blk_rd_gnt_after", 32'(bus.rd_gnt), 1);
        check("blk_rd_ready_after", 32'(bus.rd_beat_ready), 1);
        bus.rd_req = 0;
        tick();
        check("blk_rd_drain", 32'(bus.rd_beat_ready), 0);
        bus.rd_beat_valid = 0;
        tick();
        check("blk_rd_done", 32'({bus.rd_data_valid, bus.rd_done}), 3);
        check("blk_rd_data", bus.rd_data, 32'hA0);
        tick();
        check("blk_rd_gnt_drop", 32'(bus.rd_gnt), 0);

        // reset in the middle of a read burst
        bus.rd_req = 1; bus.rd_len = 3;
        tick();
        bus.rd_req = 0; bus.rd_beat_valid = 1; bus.rd_addr = 11;
        tick();
        check("mid_mem_en", 32'(bus.mem_en), 1);
        ARESET = 1;
        #1;
        check("mid_rst_gnt", 32'({bus.rd_gnt, bus.wr_gnt}), 0);
        check("mid_rst_mem", 32'({bus.mem_en, bus.mem_we}), 0);
        check("mid_rst_ready", 32'(bus.rd_beat_ready), 0);
        bus.rd_beat_valid = 0;
        tick();
        ARESET = 0;
        tick();
        check("mid_discard", 32'(bus.rd_data_valid), 0);
        check("mid_idle", 32'(bus.rd_gnt), 0);
        bus.wr_req = 1; bus.wr_len = 0;
        tick();
        check("mid_regrant", 32'(bus.wr_gnt), 1);
        bus.wr_req = 0; bus.wr_beat_valid = 1; bus.wr_addr = 40; bus.wr_data = 32'h55;
        tick();
        check("mid_wr_done", 32'(bus.wr_done), 1);
        check("mid_wr_addr", 32'(bus.mem_addr), 40);
        bus.wr_beat_valid = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
